jt89_wr_ctrl: RTL and testbench

//  CPU write-port controller for the JT89 PSG. Decodes the SN76489 latch/data byte

---
 rtl/jt89_pkg.sv | 40 ++++
 rtl/jt89_busy_cnt.sv | 33 +++
 rtl/jt89_wr_ctrl.sv | 162 ++++++++++++++++
 tb/tb_jt89_wr_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt89_pkg.sv
// Shared constants and types for the JT89 CPU write port.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package jt89_pkg;

  // Field positions inside a latch byte: {1, ch[1:0], type, data[3:0]}
  localparam int LATCH_BIT = 7;
  localparam int CH_MSB    = 6;
  localparam int CH_LSB    = 5;
  localparam int TYPE_BIT  = 4;

  // Attenuation value that mutes a channel
  localparam logic [3:0] VOL_SILENT = 4'hF;

  // Register type selector: 1 = attenuation, 0 = tone period / noise control
  localparam logic       TYPE_VOL = 1'b1;

  // Channel 3 is the noise channel; its "tone" slot holds the noise control
  localparam logic [1:0] CH_NOISE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } wr_state_e;

  // Currently addressed register
  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
  } latch_t;

  // Latch bytes replace the low nibble of a period, data bytes the upper six bits
  function automatic logic [9:0] tone_upd(input logic [9:0] cur,
                                          input logic       is_latch,
                                          input logic [7:0] d);
    if (is_latch) return {cur[9:4], d[3:0]};
    else          return {d[5:0], cur[3:0]};
  endfunction

endpackage

// File: rtl/jt89_busy_cnt.sv
// Down-counter with synchronous load and a zero flag, advanced only when enabled.
// Latency: load/decrement visible 1 clk after the edge; zero flag is combinational from the count.
// Backpressure: none; it saturates at zero instead of wrapping.
module jt89_busy_cnt #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load wins over counting; counting stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/jt89_wr_ctrl.sv
// SN76489 CPU write port: latch/data byte decode into tone/volume/noise registers plus READY.
// Latency: register outputs and noise_rst change 1 clk after the write event; ready drops the same clk.
// Backpressure: ready stays low for READY_CYC clk_en ticks; writes arriving while low are dropped.
module jt89_wr_ctrl
  import jt89_pkg::*;
#(
  parameter int READY_CYC = 32,
  parameter int CW        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       noise_rst
);

  wr_state_e  state_q, state_d;
  logic       we, we_q, wr_evt, accept;
  logic       cnt_load, cnt_zero;
  latch_t     latch_q, latch_d, sel;
  logic [9:0] tone0_q, tone0_d, tone1_q, tone1_d, tone2_q, tone2_d;
  logic [3:0] vol0_q, vol0_d, vol1_q, vol1_d, vol2_q, vol2_d, vol3_q, vol3_d;
  logic [2:0] ctrl3_q, ctrl3_d;
  logic       noise_rst_q, noise_rst_d;

  // A held strobe must yield a single event, so detect its rising edge
  assign we     = ~cs_n & ~wr_n;
  assign wr_evt = we & ~we_q;
  assign accept = wr_evt & (state_q == ST_IDLE);

  // Strobe history for edge detection
  always_ff @(posedge clk) begin
    if (rst) we_q <= 1'b0;
    else     we_q <= we;
  end

  // Busy timer: counts clk_en ticks only while busy
  jt89_busy_cnt #(
    .CW(CW)
  ) u_busy_cnt (
    .clk       (clk),
    .rst       (rst),
    .en_i      (clk_en & (state_q == ST_BUSY)),
    .load_i    (cnt_load),
    .load_val_i(CW'(READY_CYC - 1)),
    .zero_o    (cnt_zero)
  );

  // Handshake state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Idle accepts one write and arms the timer; busy leaves on the tick that finds the count at zero
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_evt) begin
          state_d  = ST_BUSY;
          cnt_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (clk_en && cnt_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte decode: a latch byte retargets and writes; a data byte writes the latched target
  always_comb begin
    latch_d     = latch_q;
    sel         = latch_q;
    tone0_d     = tone0_q;
    tone1_d     = tone1_q;
    tone2_d     = tone2_q;
    vol0_d      = vol0_q;
    vol1_d      = vol1_q;
    vol2_d      = vol2_q;
    vol3_d      = vol3_q;
    ctrl3_d     = ctrl3_q;
    noise_rst_d = 1'b0;
    if (accept) begin
      if (din[LATCH_BIT]) begin
        sel.ch  = din[CH_MSB:CH_LSB];
        sel.typ = din[TYPE_BIT];
        latch_d = sel;
      end
      if (sel.typ == TYPE_VOL) begin
        case (sel.ch)
          2'd0: vol0_d = din[3:0];
          2'd1: vol1_d = din[3:0];
          2'd2: vol2_d = din[3:0];
          2'd3: vol3_d = din[3:0];
        endcase
      end else begin
        case (sel.ch)
          2'd0: tone0_d = tone_upd(tone0_q, din[LATCH_BIT], din);
          2'd1: tone1_d = tone_upd(tone1_q, din[LATCH_BIT], din);
          2'd2: tone2_d = tone_upd(tone2_q, din[LATCH_BIT], din);
          CH_NOISE: begin
            ctrl3_d     = din[2:0];
            noise_rst_d = 1'b1;
          end
        endcase
      end
    end
  end

  // Register file, latch and the noise LFSR reset pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q     <= '0;
      tone0_q     <= '0;
      tone1_q     <= '0;
      tone2_q     <= '0;
      vol0_q      <= VOL_SILENT;
      vol1_q      <= VOL_SILENT;
      vol2_q      <= VOL_SILENT;
      vol3_q      <= VOL_SILENT;
      ctrl3_q     <= '0;
      noise_rst_q <= 1'b0;
    end else begin
      latch_q     <= latch_d;
      tone0_q     <= tone0_d;
      tone1_q     <= tone1_d;
      tone2_q     <= tone2_d;
      vol0_q      <= vol0_d;
      vol1_q      <= vol1_d;
      vol2_q      <= vol2_d;
      vol3_q      <= vol3_d;
      ctrl3_q     <= ctrl3_d;
      noise_rst_q <= noise_rst_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign tone0     = tone0_q;
  assign tone1     = tone1_q;
  assign tone2     = tone2_q;
  assign vol0      = vol0_q;
  assign vol1      = vol1_q;
  assign vol2      = vol2_q;
  assign vol3      = vol3_q;
  assign ctrl3     = ctrl3_q;
  assign noise_rst = noise_rst_q;

endmodule

// File: tb/tb_jt89_wr_ctrl.sv
// Bench for jt89_wr_ctrl: directed protocol cases followed by randomized bus traffic.
// Latency: every output is compared each cycle against a reference model of the write protocol.
// Backpressure: random clk_en stretches the busy window; writes during busy must be dropped.
module tb_jt89_wr_ctrl;

  localparam int READY_CYC = 32;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       cs_n;
  logic       wr_n;
  logic [7:0] din;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       noise_rst;

  jt89_wr_ctrl #(
    .READY_CYC(READY_CYC),
    .CW       (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .din      (din),
    .ready    (ready),
    .tone0    (tone0),
    .tone1    (tone1),
    .tone2    (tone2),
    .vol0     (vol0),
    .vol1     (vol1),
    .vol2     (vol2),
    .vol3     (vol3),
    .ctrl3    (ctrl3),
    .noise_rst(noise_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the chip's programmer-visible state after each clock
  int m_tone[3];
  int m_vol[4];
  int m_ctrl3;
  int m_ch, m_typ;
  int m_busy;       // clk_en ticks still to wait before the port is free again
  bit m_we_prev;
  bit m_nrst;

  bit en_rand   = 1'b0;
  int busy_ticks = 0;
  int falls      = 0;
  bit prev_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 0;
    for (int i = 0; i < 4; i++) m_vol[i] = 'hF;
    m_ctrl3   = 0;
    m_ch      = 0;
    m_typ     = 0;
    m_busy    = 0;
    m_we_prev = 1'b0;
    m_nrst    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs presently driven
  task automatic model_update();
    bit we, evt;
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    we        = !cs_n && !wr_n;
    evt       = we && !m_we_prev;
    m_we_prev = we;
    m_nrst    = 1'b0;
    d         = int'(din);
    if (m_busy > 0) begin
      if (clk_en) m_busy--;
    end else if (evt) begin
      m_busy = READY_CYC;
      if (d >= 128) begin
        m_ch  = (d / 32) % 4;
        m_typ = (d / 16) % 2;
      end
      if (m_typ == 1)
        m_vol[m_ch] = d % 16;
      else if (m_ch == 3) begin
        m_ctrl3 = d % 8;
        m_nrst  = 1'b1;
      end else if (d >= 128)
        m_tone[m_ch] = (m_tone[m_ch] / 16) * 16 + d % 16;
      else
        m_tone[m_ch] = (d % 64) * 16 + m_tone[m_ch] % 16;
    end
  endtask

  task automatic compare_all();
    chk("ready",     32'(ready),     32'(m_busy == 0));
    chk("tone0",     32'(tone0),     32'(m_tone[0]));
    chk("tone1",     32'(tone1),     32'(m_tone[1]));
    chk("tone2",     32'(tone2),     32'(m_tone[2]));
    chk("vol0",      32'(vol0),      32'(m_vol[0]));
    chk("vol1",      32'(vol1),      32'(m_vol[1]));
    chk("vol2",      32'(vol2),      32'(m_vol[2]));
    chk("vol3",      32'(vol3),      32'(m_vol[3]));
    chk("ctrl3",     32'(ctrl3),     32'(m_ctrl3));
    chk("noise_rst", 32'(noise_rst), 32'(m_nrst));
  endtask

  // One clock: pick clk_en, step the model, let the edge pass, compare on the falling edge
  task automatic tick();
    clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!ready && clk_en) busy_ticks++;
    prev_ready = ready;
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    if (prev_ready && !ready) falls++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 2000) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
  endtask

  // One-clock strobe; busy_ticks restarts right after the event edge
  task automatic wr(input logic [7:0] b);
    cs_n = 1'b0;
    wr_n = 1'b0;
    din  = b;
    tick();
    busy_ticks = 0;
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b0;
    cs_n   = 1'b1;
    wr_n   = 1'b1;
    din    = 8'h00;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset values
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_tone0", 32'(tone0), 32'h000);
    chk("rst_vol2",  32'(vol2),  32'hF);
    chk("rst_ctrl3", 32'(ctrl3), 32'd0);
    chk("rst_nrst",  32'(noise_rst), 32'd0);

    // Tone period assembled from latch + data bytes, busy window length
    en_rand = 1'b1;
    wr(8'h8E);
    wait_ready();
    chk("busy_ticks_1", 32'(busy_ticks), 32'(READY_CYC));
    wr(8'h0F);
    wait_ready();
    chk("busy_ticks_2", 32'(busy_ticks), 32'(READY_CYC));
    chk("tone0_0FE", 32'(tone0), 32'h0FE);

    // Volume write, then a write during busy is dropped
    wr(8'h9A);
    chk("ready_low", 32'(ready), 32'd0);
    wr(8'hB0);
    chk("vol0_A",  32'(vol0), 32'hA);
    chk("vol1_F",  32'(vol1), 32'hF);
    wait_ready();

    // Noise control via latch byte, then via data byte
    cs_n = 1'b0; wr_n = 1'b0; din = 8'hE5;
    tick();
    chk("ctrl3_101", 32'(ctrl3), 32'b101);
    chk("nrst_on_1", 32'(noise_rst), 32'd1);
    cs_n = 1'b1; wr_n = 1'b1;
    tick();
    chk("nrst_off_1", 32'(noise_rst), 32'd0);
    wait_ready();
    cs_n = 1'b0; wr_n = 1'b0; din = 8'h02;
    tick();
    chk("ctrl3_010", 32'(ctrl3), 32'b010);
    chk("nrst_on_2", 32'(noise_rst), 32'd1);
    cs_n = 1'b1; wr_n = 1'b1;
    tick();
    chk("nrst_off_2", 32'(noise_rst), 32'd0);
    wait_ready();

    // Held strobe: one event, one busy period
    en_rand = 1'b0;
    falls = 0;
    cs_n = 1'b0; wr_n = 1'b0; din = 8'hFF;
    for (int i = 0; i < 100; i++) tick();
    cs_n = 1'b1; wr_n = 1'b1;
    tick();
    chk("hold_periods", 32'(falls), 32'd1);
    chk("hold_vol3",    32'(vol3),  32'hF);
    chk("hold_ready",   32'(ready), 32'd1);

    // Reset in the middle of a busy period
    en_rand = 1'b1;
    wr(8'hC3);
    wait_ready();
    wr(8'h3F);
    chk("tone2_3F3", 32'(tone2), 32'h3F3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_tone2", 32'(tone2), 32'h000);
    chk("mid_rst_tone0", 32'(tone0), 32'h000);
    chk("mid_rst_vol0",  32'(vol0),  32'hF);
    chk("mid_rst_ctrl3", 32'(ctrl3), 32'd0);
    tick();

    // Randomized bus traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      en_rand = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 99));
      rst = ($urandom_range(0, 399) == 0);
      din = 8'($urandom);
      if (m_busy == 0 && r < 50) begin
        cs_n = 1'b0; wr_n = 1'b0;
      end else if (r < 70) begin
        cs_n = 1'b0; wr_n = 1'b0;
      end else if (r < 80) begin
        cs_n = 1'($urandom_range(0, 1));
        wr_n = ~cs_n;
      end else begin
        cs_n = 1'b1; wr_n = 1'b1;
      end
      tick();
    end
    rst  = 1'b0;
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
